// File: rtl/decode_queue.sv
// RV32I decode stage with a DEPTH-entry in-order queue between fetch and dispatch.
// Optional macro DECODE_ILLEGAL_DETECT_EN adds per-entry illegal-instruction flagging.
module decode_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PC_W  = 32,
  parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [PC_W-1:0]  in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [6:0]       out_opcode,
  output logic [2:0]       out_funct3,
  output logic [6:0]       out_funct7,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
  output logic [4:0]       out_rd,
  output logic [31:0]      out_imm,
  output logic [2:0]       out_fmt,
  output logic [PC_W-1:0]  out_pc,
  output logic             out_illegal,
  output logic [CNT_W-1:0] count
);

  localparam int unsigned AW = $clog2(DEPTH);

  localparam logic [2:0] FMT_R    = 3'd0;
  localparam logic [2:0] FMT_I    = 3'd1;
  localparam logic [2:0] FMT_S    = 3'd2;
  localparam logic [2:0] FMT_B    = 3'd3;
  localparam logic [2:0] FMT_U    = 3'd4;
  localparam logic [2:0] FMT_J    = 3'd5;
  localparam logic [2:0] FMT_NONE = 3'd7;

  typedef struct packed {
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [31:0]     imm;
    logic [2:0]      fmt;
    logic [PC_W-1:0] pc;
  } entry_t;

  entry_t        mem [DEPTH];
  entry_t        dec;
  entry_t        head;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push;
  logic          pop;

  // Handshake flags are pure functions of the registered occupancy.
  assign in_ready  = (count < CNT_W'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;

  // Field extraction and immediate formation for the incoming instruction.
  always_comb begin
    dec        = '0;
    dec.opcode = in_inst[6:0];
    dec.funct3 = in_inst[14:12];
    dec.funct7 = in_inst[31:25];
    dec.rs1    = in_inst[19:15];
    dec.rs2    = in_inst[24:20];
    dec.rd     = in_inst[11:7];
    dec.pc     = in_pc;
    dec.fmt    = FMT_NONE;
    case (in_inst[6:0])
      7'b0010011, 7'b0000011, 7'b1100111: begin
        dec.fmt = FMT_I;
        dec.imm = {{20{in_inst[31]}}, in_inst[31:20]};
      end
      7'b0100011: begin
        dec.fmt = FMT_S;
        dec.imm = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
      end
      7'b1100011: begin
        dec.fmt = FMT_B;
        dec.imm = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
      end
      7'b0110111, 7'b0010111: begin
        dec.fmt = FMT_U;
        dec.imm = {in_inst[31:12], 12'b0};
      end
      7'b1101111: begin
        dec.fmt = FMT_J;
        dec.imm = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};
      end
      7'b0110011: dec.fmt = FMT_R;
      default: ;
    endcase
  end

  // Queue storage, pointers and occupancy; flush wins over push and pop.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= dec;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  assign head       = mem[rd_ptr];
  assign out_opcode = head.opcode;
  assign out_funct3 = head.funct3;
  assign out_funct7 = head.funct7;
  assign out_rs1    = head.rs1;
  assign out_rs2    = head.rs2;
  assign out_rd     = head.rd;
  assign out_imm    = head.imm;
  assign out_fmt    = head.fmt;
  assign out_pc     = head.pc;

`ifdef DECODE_ILLEGAL_DETECT_EN
  logic             dec_ill;
  logic [DEPTH-1:0] ill_mem;

  // SYSTEM and FENCE are legal but carry no immediate format.
  always_comb begin
    dec_ill = 1'b0;
    case (in_inst[6:0])
      7'b0010011, 7'b0000011, 7'b1100111, 7'b0100011, 7'b1100011,
      7'b0110111, 7'b0010111, 7'b1101111, 7'b1110011, 7'b0001111: ;
      7'b0110011: dec_ill = (in_inst[31:25] != 7'b0000000) && (in_inst[31:25] != 7'b0100000);
      default:    dec_ill = 1'b1;
    endcase
    if (in_inst[1:0] != 2'b11) dec_ill = 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ill_mem <= '0;
    end else if (!flush && push) begin
      ill_mem[wr_ptr] <= dec_ill;
    end
  end

  assign out_illegal = ill_mem[rd_ptr];
`else
  assign out_illegal = 1'b0;
`endif

endmodule

// File: tb/tb_decode_queue.sv
// Directed bench for decode_queue: decode vector table plus queue-model sequences
// for fill, wrap-around, steady streaming, flush and asynchronous reset.
module tb_decode_queue;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned PC_W  = 32;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

`ifdef DECODE_ILLEGAL_DETECT_EN
  localparam bit ILL_EN = 1'b1;
`else
  localparam bit ILL_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rstn;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_inst;
  logic [PC_W-1:0]  in_pc;
  logic             out_valid;
  logic             out_ready;
  logic [6:0]       out_opcode;
  logic [2:0]       out_funct3;
  logic [6:0]       out_funct7;
  logic [4:0]       out_rs1;
  logic [4:0]       out_rs2;
  logic [4:0]       out_rd;
  logic [31:0]      out_imm;
  logic [2:0]       out_fmt;
  logic [PC_W-1:0]  out_pc;
  logic             out_illegal;
  logic [CNT_W-1:0] count;

  decode_queue #(.DEPTH(DEPTH), .PC_W(PC_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rstn(rstn), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_opcode(out_opcode), .out_funct3(out_funct3), .out_funct7(out_funct7),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
    .out_imm(out_imm), .out_fmt(out_fmt), .out_pc(out_pc),
    .out_illegal(out_illegal), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [2:0]  fmt;
    logic        ill;
  } vec_t;

  typedef struct {
    logic [31:0] imm;
    logic [31:0] pc;
  } ent_t;

  vec_t vecs[$];
  ent_t mq[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] addi_inst(input int k);
    logic [11:0] imm12;
    imm12 = 12'(k);
    return {imm12, 5'd0, 3'd0, 5'd1, 7'h13};
  endfunction

  // One cycle against the reference queue model; checks handshakes and the popped head.
  task automatic cyc(input bit iv, input bit ordy, input int k);
    bit exp_push;
    bit exp_pop;
    ent_t e;
    in_valid  = iv;
    out_ready = ordy;
    in_inst   = addi_inst(k);
    in_pc     = 32'h1000 + 32'(4 * k);
    exp_push  = iv && (mq.size() < DEPTH);
    exp_pop   = ordy && (mq.size() != 0);
    chk("in_ready", 32'(in_ready), 32'(mq.size() < DEPTH));
    chk("out_valid", 32'(out_valid), 32'(mq.size() != 0));
    chk("count", 32'(count), 32'(mq.size()));
    if (exp_pop) begin
      chk("head_imm", out_imm, mq[0].imm);
      chk("head_pc", out_pc, mq[0].pc);
    end
    step();
    if (exp_pop) void'(mq.pop_front());
    if (exp_push) begin
      e.imm = 32'(k);
      e.pc  = 32'h1000 + 32'(4 * k);
      mq.push_back(e);
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
  endtask

  task automatic add_vec(input logic [31:0] inst, input logic [31:0] pc, input logic [6:0] op,
                         input logic [2:0] f3, input logic [6:0] f7, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [4:0] rd, input logic [31:0] imm,
                         input logic [2:0] fmt, input logic ill);
    vec_t v;
    v.inst = inst; v.pc = pc; v.opcode = op; v.funct3 = f3; v.funct7 = f7;
    v.rs1 = rs1; v.rs2 = rs2; v.rd = rd; v.imm = imm; v.fmt = fmt; v.ill = ill;
    vecs.push_back(v);
  endtask

  initial begin
    vec_t v;
    rstn = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_inst = '0; in_pc = '0;

    //        inst          pc           op     f3    f7     rs1    rs2    rd     imm           fmt  ill
    add_vec(32'h00500093, 32'h100, 7'h13, 3'd0, 7'h00, 5'd0,  5'd5,  5'd1,  32'h00000005, 3'd1, 1'b0);
    add_vec(32'hFE20AE23, 32'h104, 7'h23, 3'd2, 7'h7F, 5'd1,  5'd2,  5'h1C, 32'hFFFFFFFC, 3'd2, 1'b0);
    add_vec(32'hFE000CE3, 32'h108, 7'h63, 3'd0, 7'h7F, 5'd0,  5'd0,  5'h19, 32'hFFFFFFF8, 3'd3, 1'b0);
    add_vec(32'h123452B7, 32'h10C, 7'h37, 3'd5, 7'h09, 5'd8,  5'd3,  5'd5,  32'h12345000, 3'd4, 1'b0);
    add_vec(32'h002081B3, 32'h110, 7'h33, 3'd0, 7'h00, 5'd1,  5'd2,  5'd3,  32'h00000000, 3'd0, 1'b0);
    add_vec(32'h010000EF, 32'h114, 7'h6F, 3'd0, 7'h00, 5'd0,  5'd16, 5'd1,  32'h00000010, 3'd5, 1'b0);
    add_vec(32'hFFDFF06F, 32'h118, 7'h6F, 3'd7, 7'h7F, 5'd31, 5'd29, 5'd0,  32'hFFFFFFFC, 3'd5, 1'b0);
    add_vec(32'hFFF12303, 32'h11C, 7'h03, 3'd2, 7'h7F, 5'd2,  5'd31, 5'd6,  32'hFFFFFFFF, 3'd1, 1'b0);
    add_vec(32'h00001517, 32'h120, 7'h17, 3'd1, 7'h00, 5'd0,  5'd0,  5'd10, 32'h00001000, 3'd4, 1'b0);
    add_vec(32'h00000073, 32'h124, 7'h73, 3'd0, 7'h00, 5'd0,  5'd0,  5'd0,  32'h00000000, 3'd7, 1'b0);
    add_vec(32'h00000000, 32'h128, 7'h00, 3'd0, 7'h00, 5'd0,  5'd0,  5'd0,  32'h00000000, 3'd7, 1'b1);
    add_vec(32'h022081B3, 32'h12C, 7'h33, 3'd0, 7'h01, 5'd1,  5'd2,  5'd3,  32'h00000000, 3'd0, 1'b1);

    // Reset state
    step(); step();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_imm", out_imm, 32'd0);
    chk("rst_pc", out_pc, 32'd0);
    chk("rst_opcode", 32'(out_opcode), 32'd0);
    rstn = 1'b1;
    step();

    // Decode table: each instruction pushed into an empty queue, checked, then popped
    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      in_valid = 1'b1; in_inst = v.inst; in_pc = v.pc;
      step();
      in_valid = 1'b0;
      chk("dec_valid", 32'(out_valid), 32'd1);
      chk("dec_opcode", 32'(out_opcode), 32'(v.opcode));
      chk("dec_funct3", 32'(out_funct3), 32'(v.funct3));
      chk("dec_funct7", 32'(out_funct7), 32'(v.funct7));
      chk("dec_rs1", 32'(out_rs1), 32'(v.rs1));
      chk("dec_rs2", 32'(out_rs2), 32'(v.rs2));
      chk("dec_rd", 32'(out_rd), 32'(v.rd));
      chk("dec_imm", out_imm, v.imm);
      chk("dec_fmt", 32'(out_fmt), 32'(v.fmt));
      chk("dec_pc", out_pc, v.pc);
      chk("dec_illegal", 32'(out_illegal), 32'(v.ill && ILL_EN));
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk("dec_drained", 32'(count), 32'd0);
    end

    // Back-to-back sw, beq, lui; popped in order
    for (int i = 1; i <= 3; i++) begin
      in_valid = 1'b1; in_inst = vecs[i].inst; in_pc = vecs[i].pc;
      step();
    end
    in_valid = 1'b0;
    chk("b2b_count", 32'(count), 32'd3);
    out_ready = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      chk("b2b_imm", out_imm, vecs[i].imm);
      chk("b2b_fmt", 32'(out_fmt), 32'(vecs[i].fmt));
      step();
    end
    out_ready = 1'b0;
    chk("b2b_empty", 32'(out_valid), 32'd0);

    // Fill to full, extra push ignored, pop at full, then wrap over 3*DEPTH entries
    for (int k = 0; k < int'(DEPTH); k++) cyc(1'b1, 1'b0, k);
    cyc(1'b1, 1'b0, 50);
    cyc(1'b1, 1'b1, 51);
    cyc(1'b1, 1'b0, 52);
    for (int k = 100; k < 100 + 3 * int'(DEPTH); k++) cyc(1'b1, 1'b1, k);
    for (int k = 0; k < int'(DEPTH) + 1; k++) cyc(1'b0, 1'b1, 0);

    // Steady push+pop at count=2 for 10 cycles
    cyc(1'b1, 1'b0, 200);
    cyc(1'b1, 1'b0, 201);
    for (int k = 202; k < 212; k++) cyc(1'b1, 1'b1, k);
    chk("steady_count", 32'(count), 32'd2);
    for (int k = 0; k < 3; k++) cyc(1'b0, 1'b1, 0);

    // Flush at count=3 while pushing and popping
    for (int k = 300; k < 303; k++) cyc(1'b1, 1'b0, k);
    flush = 1'b1; in_valid = 1'b1; out_ready = 1'b1; in_inst = addi_inst(399);
    step();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    mq.delete();
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_valid", 32'(out_valid), 32'd0);
    cyc(1'b1, 1'b0, 310);
    cyc(1'b0, 1'b1, 0);
    cyc(1'b0, 1'b0, 0);

    // Asynchronous reset mid-stream at count=2
    cyc(1'b1, 1'b0, 400);
    cyc(1'b1, 1'b0, 401);
    chk("pre_rst_count", 32'(count), 32'd2);
    rstn = 1'b0;
    #1;
    chk("async_rst_valid", 32'(out_valid), 32'd0);
    chk("async_rst_count", 32'(count), 32'd0);
    chk("async_rst_ready", 32'(in_ready), 32'd1);
    mq.delete();
    step();
    rstn = 1'b1;
    step();
    in_valid = 1'b1; in_inst = 32'h00000000; in_pc = 32'h200;
    step();
    in_valid = 1'b0;
    chk("zero_inst_valid", 32'(out_valid), 32'd1);
    chk("zero_inst_illegal", 32'(out_illegal), 32'(ILL_EN));
    chk("zero_inst_fmt", 32'(out_fmt), 32'd7);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
